// File: rtl/delay_tap_reader_if.sv
// Sample-in / tap-out stream bundle for delay_tap_reader.
// master = the delay line (producer of taps), slave = the feeder/consumer side.
interface delay_tap_reader_if #(
  parameter int BITWIDTH_DATA = 16,
  parameter int LENGTH        = 32
);
  logic                       START_FLAG;
  logic [BITWIDTH_DATA-1:0]   DATA_IN;
  logic [BITWIDTH_DATA-1:0]   TAP_DATA;
  logic [$clog2(LENGTH):0]    TAP_IDX;
  logic                       TAP_VALID;
  logic                       TAP_READY;
  logic                       TAP_LAST;

  modport master (
    input  START_FLAG, DATA_IN, TAP_READY,
    output TAP_DATA, TAP_IDX, TAP_VALID, TAP_LAST
  );

  modport slave (
    output START_FLAG, DATA_IN, TAP_READY,
    input  TAP_DATA, TAP_IDX, TAP_VALID, TAP_LAST
  );
endinterface

// File: rtl/delay_tap_reader.sv
// Circular delay line: each accepted sample triggers a burst of all LENGTH taps,
// newest first, over a valid/ready stream. Samples arriving mid-burst are dropped.
module delay_tap_reader #(
  parameter int BITWIDTH_DATA = 16,
  parameter int LENGTH        = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                EN,
  delay_tap_reader_if.master  tap,
  output logic                BUSY,
  output logic                OVERRUN
);
  localparam int PTR_W = $clog2(LENGTH);
  localparam int IDX_W = $clog2(LENGTH) + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(LENGTH);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                   state_r, state_s;
  logic [PTR_W-1:0]         wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]         newest_r, newest_s;
  logic [IDX_W-1:0]         tap_cnt_r, tap_cnt_s;
  logic [IDX_W-1:0]         nxt_idx_s;
  logic                     tap_last_r, tap_last_s;
  logic [BITWIDTH_DATA-1:0] tap_data_r, tap_data_s;
  logic                     overrun_r, overrun_s;
  logic                     wr_en_s;
  logic [BITWIDTH_DATA-1:0] buf_r [LENGTH];

  // Slot holding the sample idx steps older than newest, wrapping for any LENGTH.
  function automatic logic [PTR_W-1:0] rd_addr(input logic [PTR_W-1:0] newest,
                                               input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] n;
    n = {1'b0, newest};
    if (n >= idx) begin
      rd_addr = PTR_W'(n - idx);
    end else begin
      rd_addr = PTR_W'(n + LEN_IDX - idx);
    end
  endfunction

  assign nxt_idx_s = tap_cnt_r + IDX_W'(1);

  // Next-state and next-output logic; tap data is prefetched one step ahead.
  always_comb begin
    state_s    = state_r;
    wr_ptr_s   = wr_ptr_r;
    newest_s   = newest_r;
    tap_cnt_s  = tap_cnt_r;
    tap_last_s = tap_last_r;
    tap_data_s = tap_data_r;
    overrun_s  = overrun_r;
    wr_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (tap.START_FLAG) begin
          wr_en_s    = 1'b1;
          newest_s   = wr_ptr_r;
          wr_ptr_s   = (wr_ptr_r == LAST_PTR) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
          tap_cnt_s  = {IDX_W{1'b0}};
          tap_last_s = 1'b0;
          tap_data_s = tap.DATA_IN;
          state_s    = STREAM;
        end else begin
          state_s    = IDLE;
        end
      end
      STREAM: begin
        if (tap.START_FLAG) begin
          overrun_s = 1'b1;
        end else begin
          overrun_s = overrun_r;
        end
        if (tap.TAP_READY && tap_last_r) begin
          state_s    = IDLE;
          tap_cnt_s  = {IDX_W{1'b0}};
          tap_last_s = 1'b0;
          tap_data_s = {BITWIDTH_DATA{1'b0}};
        end else if (tap.TAP_READY) begin
          tap_cnt_s  = nxt_idx_s;
          tap_last_s = (nxt_idx_s == LAST_IDX);
          tap_data_s = buf_r[rd_addr(newest_r, nxt_idx_s)];
        end else begin
          state_s    = STREAM;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control and output registers; EN low clears everything like reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r    <= IDLE;
      wr_ptr_r   <= {PTR_W{1'b0}};
      newest_r   <= {PTR_W{1'b0}};
      tap_cnt_r  <= {IDX_W{1'b0}};
      tap_last_r <= 1'b0;
      tap_data_r <= {BITWIDTH_DATA{1'b0}};
      overrun_r  <= 1'b0;
    end else if (!EN) begin
      state_r    <= IDLE;
      wr_ptr_r   <= {PTR_W{1'b0}};
      newest_r   <= {PTR_W{1'b0}};
      tap_cnt_r  <= {IDX_W{1'b0}};
      tap_last_r <= 1'b0;
      tap_data_r <= {BITWIDTH_DATA{1'b0}};
      overrun_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      wr_ptr_r   <= wr_ptr_s;
      newest_r   <= newest_s;
      tap_cnt_r  <= tap_cnt_s;
      tap_last_r <= tap_last_s;
      tap_data_r <= tap_data_s;
      overrun_r  <= overrun_s;
    end
  end

  // Sample storage; zeroed so never-written taps read as 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < LENGTH; i++) buf_r[i] <= {BITWIDTH_DATA{1'b0}};
    end else if (!EN) begin
      for (int i = 0; i < LENGTH; i++) buf_r[i] <= {BITWIDTH_DATA{1'b0}};
    end else if (wr_en_s) begin
      buf_r[wr_ptr_r] <= tap.DATA_IN;
    end else begin
      buf_r[wr_ptr_r] <= buf_r[wr_ptr_r];
    end
  end

  assign tap.TAP_VALID = (state_r == STREAM);
  assign tap.TAP_IDX   = tap_cnt_r;
  assign tap.TAP_LAST  = tap_last_r;
  assign tap.TAP_DATA  = tap_data_r;
  assign BUSY          = (state_r == STREAM);
  assign OVERRUN       = overrun_r;
endmodule
